piso_stream: RTL and testbench

- Parametrised parallel-in/serial-out converter with a valid/ready input handshake, a one-word holding buffer, and multi-lane serial output.
- Accepts DATA_WIDTH-bit words and emits each word as BEATS = DATA_WIDTH/LANES beats of LANES bits.
- Supports programmable bit order and an external beat-advance strobe.
- Sits between a word-oriented producer and a serial link or PHY; back-to-back words stream with zero gap.

---
 rtl/piso_stream.sv | 123 ++++++++++++
 tb/tb_piso_stream.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/piso_stream.sv
// piso_stream: parallel-in/serial-out converter with a one-word holding buffer,
// valid/ready input handshake and LANES-bit serial beats.
module piso_stream #(
    parameter int DATA_WIDTH = 8,
    parameter int LANES      = 1,
    parameter bit MSB_FIRST  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] parallel_in,
    input  logic                  shift_en,
    input  logic                  flush,
    output logic [LANES-1:0]      serial_out,
    output logic                  out_valid,
    output logic                  out_first,
    output logic                  out_last,
    output logic                  busy
);

    localparam int BEATS = DATA_WIDTH / LANES;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BEATS - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t                state_r, state_s;
    logic [DATA_WIDTH-1:0] shreg_r, shreg_s;
    logic [DATA_WIDTH-1:0] hold_r, hold_s;
    logic                  hold_full_r, hold_full_s;
    logic [CNT_W-1:0]      cnt_r, cnt_s;
    logic                  out_valid_r, out_first_r, out_last_r, busy_r;
    logic                  out_valid_s;
    logic                  accept_s, last_beat_s, free_s;
    logic [DATA_WIDTH-1:0] shifted_s;

    // in_ready depends only on registered state (and reset), never on in_valid
    assign in_ready    = rstn & ~hold_full_r;
    assign accept_s    = in_valid & in_ready & ~flush;
    assign last_beat_s = (cnt_r == CNT_LAST);
    assign free_s      = (state_r == IDLE) | (last_beat_s & shift_en);
    assign shifted_s   = MSB_FIRST ? (shreg_r << LANES) : (shreg_r >> LANES);
    assign out_valid_s = (state_s == SHIFT);

    assign serial_out = MSB_FIRST ? shreg_r[DATA_WIDTH-1 -: LANES] : shreg_r[LANES-1:0];
    assign out_valid  = out_valid_r;
    assign out_first  = out_first_r;
    assign out_last   = out_last_r;
    assign busy       = busy_r;

    // Next-state: load priority when the shifter frees up, otherwise shift/stall
    always_comb begin
        state_s     = state_r;
        shreg_s     = shreg_r;
        hold_s      = hold_r;
        hold_full_s = hold_full_r;
        cnt_s       = cnt_r;
        if (free_s) begin
            if (hold_full_r) begin
                shreg_s = hold_r;
                cnt_s   = CNT_ZERO;
                state_s = SHIFT;
                if (accept_s) begin
                    hold_s = parallel_in;
                end else begin
                    hold_full_s = 1'b0;
                end
            end else if (accept_s) begin
                shreg_s = parallel_in;
                cnt_s   = CNT_ZERO;
                state_s = SHIFT;
            end else begin
                shreg_s = {DATA_WIDTH{1'b0}};
                cnt_s   = CNT_ZERO;
                state_s = IDLE;
            end
        end else begin
            if (shift_en) begin
                shreg_s = shifted_s;
                cnt_s   = cnt_r + CNT_W'(1);
            end else begin
                shreg_s = shreg_r;
            end
            if (accept_s) begin
                hold_s      = parallel_in;
                hold_full_s = 1'b1;
            end else begin
                hold_full_s = hold_full_r;
            end
        end
    end

    // State and output registers; reset and flush share the same clear
    always_ff @(posedge clk) begin
        if (!rstn || flush) begin
            state_r     <= IDLE;
            shreg_r     <= {DATA_WIDTH{1'b0}};
            hold_r      <= {DATA_WIDTH{1'b0}};
            hold_full_r <= 1'b0;
            cnt_r       <= CNT_ZERO;
            out_valid_r <= 1'b0;
            out_first_r <= 1'b0;
            out_last_r  <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            shreg_r     <= shreg_s;
            hold_r      <= hold_s;
            hold_full_r <= hold_full_s;
            cnt_r       <= cnt_s;
            out_valid_r <= out_valid_s;
            out_first_r <= out_valid_s & (cnt_s == CNT_ZERO);
            out_last_r  <= out_valid_s & (cnt_s == CNT_LAST);
            busy_r      <= out_valid_s | hold_full_s;
        end
    end

endmodule

// File: tb/tb_piso_stream.sv
// Scoreboard bench for piso_stream: 8/1/MSB-first and 8/2/LSB-first instances
// share stimulus; expected beats are queued on acceptance and checked each cycle.
module tb_piso_stream;

    typedef struct packed {
        logic [1:0] data;
        logic       first;
        logic       last;
    } beat_t;

    logic       clk;
    logic       rstn;
    logic       in_valid;
    logic [7:0] parallel_in;
    logic       shift_en;
    logic       flush;
    logic       sel;
    logic       mon_en;

    logic       ready_a, valid_a, first_a, last_a, busy_a;
    logic [0:0] serial_a;
    logic       ready_b, valid_b, first_b, last_b, busy_b;
    logic [1:0] serial_b;

    logic       m_ready, m_valid, m_first, m_last, m_busy;
    logic [1:0] m_serial;
    logic       ready_exp;

    beat_t q[$];
    int    n_tests;
    int    n_fail;

    piso_stream #(.DATA_WIDTH(8), .LANES(1), .MSB_FIRST(1'b1)) dut_a (
        .clk(clk), .rstn(rstn), .in_valid(in_valid & ~sel), .in_ready(ready_a),
        .parallel_in(parallel_in), .shift_en(shift_en), .flush(flush),
        .serial_out(serial_a), .out_valid(valid_a), .out_first(first_a),
        .out_last(last_a), .busy(busy_a)
    );

    piso_stream #(.DATA_WIDTH(8), .LANES(2), .MSB_FIRST(1'b0)) dut_b (
        .clk(clk), .rstn(rstn), .in_valid(in_valid & sel), .in_ready(ready_b),
        .parallel_in(parallel_in), .shift_en(shift_en), .flush(flush),
        .serial_out(serial_b), .out_valid(valid_b), .out_first(first_b),
        .out_last(last_b), .busy(busy_b)
    );

    assign m_ready  = sel ? ready_b : ready_a;
    assign m_valid  = sel ? valid_b : valid_a;
    assign m_first  = sel ? first_b : first_a;
    assign m_last   = sel ? last_b  : last_a;
    assign m_busy   = sel ? busy_b  : busy_a;
    assign m_serial = sel ? serial_b : {1'b0, serial_a};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Holding buffer is full when the queue holds beats beyond the current word
    function automatic bit hold_exp();
        int idx;
        idx = q.size();
        for (int i = 0; i < q.size(); i++) begin
            if (q[i].last && idx == q.size()) idx = i;
        end
        return (q.size() > idx + 1);
    endfunction

    task automatic push_word(input logic [7:0] w, input logic b);
        beat_t e;
        int    nb;
        nb = b ? 4 : 8;
        for (int i = 0; i < nb; i++) begin
            e.data  = b ? {w[2*i+1], w[2*i]} : {1'b0, w[7-i]};
            e.first = (i == 0);
            e.last  = (i == nb - 1);
            q.push_back(e);
        end
    endtask

    // Scoreboard monitor: compare on the falling edge, pop when a beat is consumed
    always @(negedge clk) begin
        if (mon_en) begin
            ready_exp = rstn && !hold_exp();
            check_val("out_valid", 32'(m_valid), 32'(q.size() != 0));
            check_val("busy", 32'(m_busy), 32'(q.size() != 0));
            check_val("in_ready", 32'(m_ready), 32'(ready_exp));
            if (q.size() != 0) begin
                check_val("serial_out", 32'(m_serial), 32'(q[0].data));
                check_val("out_first", 32'(m_first), 32'(q[0].first));
                check_val("out_last", 32'(m_last), 32'(q[0].last));
                if (shift_en) void'(q.pop_front());
            end
            if (!rstn || flush) q.delete();
            else if (in_valid && ready_exp) push_word(parallel_in, sel);
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [7:0] w);
        int n;
        n = 0;
        in_valid    = 1'b1;
        parallel_in = w;
        while (!m_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 50) check_val("send_timeout", 32'(n), 32'(0));
        else wait_cycles(1);
        in_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        n_tests = 0; n_fail = 0;
        rstn = 1'b0; in_valid = 1'b0; parallel_in = 8'h00;
        shift_en = 1'b0; flush = 1'b0; sel = 1'b0; mon_en = 1'b0;
        wait_cycles(2);
        check_val("rst_out_valid", 32'(valid_a), 32'(0));
        check_val("rst_serial", 32'(serial_a), 32'(0));
        check_val("rst_first_last", 32'({first_a, last_a}), 32'(0));
        check_val("rst_busy", 32'(busy_a), 32'(0));
        check_val("rst_in_ready_low", 32'(ready_a), 32'(0));
        rstn = 1'b1;
        #1;
        check_val("rst_in_ready_high", 32'(ready_a), 32'(1));
        mon_en = 1'b1; shift_en = 1'b1;

        // single word, then back-to-back pair through the holding buffer
        send_word(8'hA5);
        wait_cycles(10);
        send_word(8'hA5);
        send_word(8'h3C);
        wait_cycles(18);

        // stall after beat 2
        send_word(8'hF0);
        wait_cycles(2);
        shift_en = 1'b0;
        wait_cycles(5);
        shift_en = 1'b1;
        wait_cycles(8);

        // reset during beat 4 with a word held
        send_word(8'h81);
        send_word(8'h7E);
        wait_cycles(3);
        rstn = 1'b0;
        wait_cycles(1);
        rstn = 1'b1;
        #1;
        check_val("rstmid_out_valid", 32'(valid_a), 32'(0));
        check_val("rstmid_busy", 32'(busy_a), 32'(0));
        check_val("rstmid_in_ready", 32'(ready_a), 32'(1));
        wait_cycles(12);

        // flush during beat 3 while 0x55 is offered
        send_word(8'h96);
        wait_cycles(3);
        flush = 1'b1; in_valid = 1'b1; parallel_in = 8'h55;
        wait_cycles(1);
        flush = 1'b0; in_valid = 1'b0;
        check_val("flush_out_valid", 32'(valid_a), 32'(0));
        check_val("flush_in_ready", 32'(ready_a), 32'(1));
        wait_cycles(2);
        send_word(8'h55);
        wait_cycles(10);

        // two-lane LSB-first instance
        sel = 1'b1;
        send_word(8'hB4);
        wait_cycles(6);
        send_word(8'hB4);
        send_word(8'h3C);
        wait_cycles(10);
        send_word(8'($urandom_range(0, 255)));
        shift_en = 1'b0;
        wait_cycles($urandom_range(2, 6));
        shift_en = 1'b1;
        for (int k = 0; k < 4; k++) send_word(8'($urandom_range(0, 255)));
        wait_cycles(20);

        check_val("queue_drained", 32'(q.size()), 32'(0));
        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
